// File: rtl/sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_ctrl
// Purpose  : Two-master (instruction / data) arbiter and controller for two
//            asynchronous SRAM banks (base, ext). Each bank runs its own access
//            sequencer, so masters hitting different banks proceed in parallel.
//            Same-bank conflicts are resolved by fixed data priority or by a
//            per-bank round-robin bit.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr             : instruction read request (read-only port)
//   i_ready/i_done/i_rdata   : instruction accept, completion pulse, read data
//   d_req/d_we/d_sel/d_addr/d_wdata : data request, write enable, byte
//                              selects, address, write data
//   d_ready/d_done/d_err/d_rdata    : data accept, completion pulse, decode
//                              error flag, read data
//   base_* / ext_*           : SRAM bank pins (word address, active-low byte
//                              enables and strobes, data out/enable/in)
// ============================================================================
module sram_arb_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int BANK_BIT    = 22,
   parameter int PRIO_MODE   = 0
) (
   input  logic        clk,
   input  logic        rst,
   // instruction port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic        i_done,
   output logic [31:0] i_rdata,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ready,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   // base bank
   output logic [19:0] base_addr,
   output logic [3:0]  base_be_n,
   output logic        base_ce_n,
   output logic        base_oe_n,
   output logic        base_we_n,
   output logic [31:0] base_dq_o,
   output logic        base_dq_oe,
   input  logic [31:0] base_dq_i,
   // ext bank
   output logic [19:0] ext_addr,
   output logic [3:0]  ext_be_n,
   output logic        ext_ce_n,
   output logic        ext_oe_n,
   output logic        ext_we_n,
   output logic [31:0] ext_dq_o,
   output logic        ext_dq_oe,
   input  logic [31:0] ext_dq_i
);

   localparam int LAST_CNT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ACTIVE = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // Address decode: the SRAM window is 0x8000_0000..0x807F_FFFF
   // ---------------------------------------------------------------------
   logic i_valid, d_valid, i_bank, d_bank;
   assign i_valid = (i_addr[31:23] == 9'h100);
   assign d_valid = (d_addr[31:23] == 9'h100);
   assign i_bank  = i_addr[BANK_BIT];
   assign d_bank  = d_addr[BANK_BIT];

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

   logic [1:0] i_want, d_want, i_grant, d_grant;
   logic [1:0] bank_rdy, d_wins, fin, owner_data, wr;

   // ---------------------------------------------------------------------
   // Per-bank arbitration. d_wins comes from the bank's priority state and
   // decides only when both masters target the same ready bank.
   // ---------------------------------------------------------------------
   always_comb begin
      i_want  = '0;
      d_want  = '0;
      i_grant = '0;
      d_grant = '0;
      for (int b = 0; b < 2; b++) begin
         i_want[b]  = i_req && i_valid && (i_bank == 1'(b));
         d_want[b]  = d_req && d_valid && (d_bank == 1'(b));
         d_grant[b] = d_want[b] && bank_rdy[b] && (!i_want[b] || d_wins[b]);
         i_grant[b] = i_want[b] && bank_rdy[b] && (!d_want[b] || !d_wins[b]);
      end
   end

   // Out-of-window requests never touch a bank and are always accepted.
   assign i_ready = !rst && (!i_valid ||
                    (bank_rdy[i_bank] && !(d_want[i_bank] && d_wins[i_bank])));
   assign d_ready = !rst && (!d_valid ||
                    (bank_rdy[d_bank] && !(i_want[d_bank] && !d_wins[d_bank])));

   // ---------------------------------------------------------------------
   // Bank sequencers: IDLE -> SETUP -> ACTIVE(xWAIT_CYCLES) -> HOLD -> DONE
   // ---------------------------------------------------------------------
   for (genvar b = 0; b < 2; b++) begin : g_bank
      state_t      state;
      logic [3:0]  cnt;
      logic [19:0] addr;
      logic [3:0]  be_n;
      logic        ce_n, oe_n, we_n, dq_oe;
      logic [31:0] dq_o;
      logic        owner_d;     // 1 = current access belongs to data port
      logic        wr_acc;      // current access is a write
      logic        last_data;   // 1 = data port won the last conflict

      assign bank_rdy[b]   = (state == S_IDLE) || (state == S_DONE);
      assign fin[b]        = (state == S_HOLD);
      assign owner_data[b] = owner_d;
      assign wr[b]         = wr_acc;
      assign d_wins[b]     = (PRIO_MODE == 0) || !last_data;

      always_ff @(posedge clk) begin
         if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr      <= 20'd0;
            be_n      <= 4'hF;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            dq_oe     <= 1'b0;
            dq_o      <= 32'd0;
            owner_d   <= 1'b0;
            wr_acc    <= 1'b0;
            last_data <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (d_grant[b] || i_grant[b]) begin
                     if (i_want[b] && d_want[b])
                        last_data <= d_grant[b];
                     state   <= S_SETUP;
                     cnt     <= 4'd0;
                     owner_d <= d_grant[b];
                     wr_acc  <= d_grant[b] && d_we;
                     addr    <= d_grant[b] ? d_addr[21:2] : i_addr[21:2];
                     be_n    <= (d_grant[b] && d_we) ? ~d_sel : 4'h0;
                     ce_n    <= 1'b0;
                     oe_n    <= d_grant[b] && d_we;
                     we_n    <= 1'b1;
                     dq_oe   <= d_grant[b] && d_we;
                     dq_o    <= (d_grant[b] && d_we) ? d_wdata : 32'd0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
               S_SETUP: begin
                  // Write strobe spans ACTIVE, or HOLD alone with no wait states.
                  we_n <= !wr_acc;
                  cnt  <= 4'd0;
                  if (WAIT_CYCLES == 0)
                     state <= S_HOLD;
                  else
                     state <= S_ACTIVE;
               end
               S_ACTIVE: begin
                  if (cnt == 4'(LAST_CNT)) begin
                     state <= S_HOLD;
                     we_n  <= 1'b1;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               S_HOLD: begin
                  state <= S_DONE;
                  ce_n  <= 1'b1;
                  oe_n  <= 1'b1;
                  we_n  <= 1'b1;
                  be_n  <= 4'hF;
                  dq_oe <= 1'b0;
                  dq_o  <= 32'd0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign base_addr  = g_bank[0].addr;
   assign base_be_n  = g_bank[0].be_n;
   assign base_ce_n  = g_bank[0].ce_n;
   assign base_oe_n  = g_bank[0].oe_n;
   assign base_we_n  = g_bank[0].we_n;
   assign base_dq_o  = g_bank[0].dq_o;
   assign base_dq_oe = g_bank[0].dq_oe;

   assign ext_addr   = g_bank[1].addr;
   assign ext_be_n   = g_bank[1].be_n;
   assign ext_ce_n   = g_bank[1].ce_n;
   assign ext_oe_n   = g_bank[1].oe_n;
   assign ext_we_n   = g_bank[1].we_n;
   assign ext_dq_o   = g_bank[1].dq_o;
   assign ext_dq_oe  = g_bank[1].dq_oe;

   // ---------------------------------------------------------------------
   // Completion routing: the edge that ends HOLD is the read-capture edge;
   // done and rdata go only to the port that owned the finishing access.
   // ---------------------------------------------------------------------
   logic        i_fin, d_fin;
   logic [31:0] i_fin_data, d_fin_data;
   logic        i_bad, d_bad;

   assign i_bad = i_req && !i_valid;
   assign d_bad = d_req && !d_valid;

   always_comb begin
      i_fin      = 1'b0;
      d_fin      = 1'b0;
      i_fin_data = '0;
      d_fin_data = '0;
      if (fin[0]) begin
         if (owner_data[0]) begin
            d_fin      = 1'b1;
            d_fin_data = wr[0] ? 32'd0 : base_dq_i;
         end else begin
            i_fin      = 1'b1;
            i_fin_data = base_dq_i;
         end
      end
      if (fin[1]) begin
         if (owner_data[1]) begin
            d_fin      = 1'b1;
            d_fin_data = wr[1] ? 32'd0 : ext_dq_i;
         end else begin
            i_fin      = 1'b1;
            i_fin_data = ext_dq_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_done  <= 1'b0;
         i_rdata <= 32'd0;
         d_done  <= 1'b0;
         d_err   <= 1'b0;
         d_rdata <= 32'd0;
      end else begin
         i_done <= i_fin || i_bad;
         if (i_fin)
            i_rdata <= i_fin_data;
         else if (i_bad)
            i_rdata <= 32'd0;

         d_done <= d_fin || d_bad;
         d_err  <= d_bad;
         if (d_fin)
            d_rdata <= d_fin_data;
         else if (d_bad)
            d_rdata <= 32'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arb_ctrl
// Purpose  : Directed self-checking bench for sram_arb_ctrl. One instance uses
//            fixed data priority, a second uses round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arb_ctrl;

   logic        clk = 1'b0;
   logic        rst;

   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_sel;
   logic        i_ready, i_done, d_ready, d_done, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic [19:0] base_addr, ext_addr;
   logic [3:0]  base_be_n, ext_be_n;
   logic        base_ce_n, base_oe_n, base_we_n, base_dq_oe;
   logic        ext_ce_n, ext_oe_n, ext_we_n, ext_dq_oe;
   logic [31:0] base_dq_o, ext_dq_o, base_dq_i, ext_dq_i;

   // round-robin instance stimulus and observed ready lines
   logic        ri_req, rd_req, rd_we;
   logic [31:0] ri_addr, rd_addr, rd_wdata;
   logic [3:0]  rd_sel;
   logic        rr_i_ready, rr_d_ready;
   logic        rr_unused_i_done, rr_unused_d_done, rr_unused_d_err;
   logic [31:0] rr_unused_i_rdata, rr_unused_d_rdata;
   logic [19:0] rr_unused_base_addr, rr_unused_ext_addr;
   logic [3:0]  rr_unused_base_be_n, rr_unused_ext_be_n;
   logic        rr_unused_base_ce_n, rr_unused_base_oe_n, rr_unused_base_we_n, rr_unused_base_dq_oe;
   logic        rr_unused_ext_ce_n, rr_unused_ext_oe_n, rr_unused_ext_we_n, rr_unused_ext_dq_oe;
   logic [31:0] rr_unused_base_dq_o, rr_unused_ext_dq_o;

   always #5 clk = ~clk;

   sram_arb_ctrl #(.WAIT_CYCLES(1), .BANK_BIT(22), .PRIO_MODE(0)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .base_addr(base_addr), .base_be_n(base_be_n), .base_ce_n(base_ce_n),
      .base_oe_n(base_oe_n), .base_we_n(base_we_n), .base_dq_o(base_dq_o),
      .base_dq_oe(base_dq_oe), .base_dq_i(base_dq_i),
      .ext_addr(ext_addr), .ext_be_n(ext_be_n), .ext_ce_n(ext_ce_n),
      .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n), .ext_dq_o(ext_dq_o),
      .ext_dq_oe(ext_dq_oe), .ext_dq_i(ext_dq_i)
   );

   sram_arb_ctrl #(.WAIT_CYCLES(1), .BANK_BIT(22), .PRIO_MODE(1)) dut_rr (
      .clk(clk), .rst(rst),
      .i_req(ri_req), .i_addr(ri_addr), .i_ready(rr_i_ready), .i_done(rr_unused_i_done),
      .i_rdata(rr_unused_i_rdata),
      .d_req(rd_req), .d_we(rd_we), .d_sel(rd_sel), .d_addr(rd_addr), .d_wdata(rd_wdata),
      .d_ready(rr_d_ready), .d_done(rr_unused_d_done), .d_err(rr_unused_d_err),
      .d_rdata(rr_unused_d_rdata),
      .base_addr(rr_unused_base_addr), .base_be_n(rr_unused_base_be_n),
      .base_ce_n(rr_unused_base_ce_n), .base_oe_n(rr_unused_base_oe_n),
      .base_we_n(rr_unused_base_we_n), .base_dq_o(rr_unused_base_dq_o),
      .base_dq_oe(rr_unused_base_dq_oe), .base_dq_i(base_dq_i),
      .ext_addr(rr_unused_ext_addr), .ext_be_n(rr_unused_ext_be_n),
      .ext_ce_n(rr_unused_ext_ce_n), .ext_oe_n(rr_unused_ext_oe_n),
      .ext_we_n(rr_unused_ext_we_n), .ext_dq_o(rr_unused_ext_dq_o),
      .ext_dq_oe(rr_unused_ext_dq_oe), .ext_dq_i(ext_dq_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          cnt_a, cnt_b, cnt_c, cnt_d, k_a, k_b, first, ng;
      logic        flag;
      logic [31:0] v_a, v_b, v_c;
      int          gw[3];
      int          gk[3];

      rst = 1'b1;
      i_req = 1'b0; i_addr = 32'd0;
      d_req = 1'b0; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'd0; d_wdata = 32'd0;
      ri_req = 1'b0; ri_addr = 32'd0;
      rd_req = 1'b0; rd_we = 1'b0; rd_sel = 4'hF; rd_addr = 32'd0; rd_wdata = 32'd0;
      base_dq_i = 32'd0; ext_dq_i = 32'd0;

      // ---------------- reset state ----------------
      tick; tick;
      check("rst_base_ce_n", 32'(base_ce_n), 32'd1);
      check("rst_base_oe_n", 32'(base_oe_n), 32'd1);
      check("rst_ext_we_n", 32'(ext_we_n), 32'd1);
      check("rst_base_be_n", 32'(base_be_n), 32'hF);
      check("rst_ext_dq_oe", 32'(ext_dq_oe), 32'd0);
      check("rst_base_addr", 32'(base_addr), 32'd0);
      check("rst_ext_dq_o", ext_dq_o, 32'd0);
      check("rst_d_done", 32'(d_done), 32'd0);
      check("rst_d_err", 32'(d_err), 32'd0);
      check("rst_i_rdata", i_rdata, 32'd0);
      d_addr = 32'h8000_0010; i_addr = 32'h8000_0020;
      #1;
      check("rst_d_ready_low", 32'(d_ready), 32'd0);
      check("rst_i_ready_low", 32'(i_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("idle_d_ready", 32'(d_ready), 32'd1);

      // ---------------- read, base bank ----------------
      tick;
      base_dq_i = 32'hA5A5_1234;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0010;
      #1;
      check("rd_d_ready", 32'(d_ready), 32'd1);
      tick;
      d_req = 1'b0;
      check("rd_base_addr", 32'(base_addr), 32'h0000_0004);
      check("rd_base_be_n", 32'(base_be_n), 32'h0);
      cnt_a = 0; cnt_b = 0; k_a = 0; v_a = 32'd0;
      for (int k = 1; k <= 6; k++) begin
         if (!base_oe_n) cnt_a++;
         if (d_done) begin cnt_b++; k_a = k; v_a = d_rdata; end
         tick;
      end
      check("rd_oe_low_cycles", 32'(cnt_a), 32'd3);
      check("rd_done_cycle", 32'(k_a), 32'd4);
      check("rd_done_width", 32'(cnt_b), 32'd1);
      check("rd_rdata", v_a, 32'hA5A5_1234);
      check("rd_rdata_hold", d_rdata, 32'hA5A5_1234);

      // ---------------- write, ext bank ----------------
      d_req = 1'b1; d_we = 1'b1; d_sel = 4'b0011;
      d_addr = 32'h8040_0008; d_wdata = 32'hDEAD_BEEF;
      #1;
      check("wr_d_ready", 32'(d_ready), 32'd1);
      tick;
      d_req = 1'b0; d_we = 1'b0; d_sel = 4'hF;
      check("wr_ext_be_n", 32'(ext_be_n), 32'hC);
      check("wr_ext_addr", 32'(ext_addr), 32'h0000_0002);
      check("wr_ext_dq_o", ext_dq_o, 32'hDEAD_BEEF);
      cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; k_a = 0; k_b = 0;
      for (int k = 1; k <= 6; k++) begin
         if (!ext_we_n) begin cnt_a++; if (k_a == 0) k_a = k; end
         if (ext_dq_oe) cnt_b++;
         if (!ext_oe_n) cnt_c++;
         if (!base_ce_n) cnt_d++;
         if (d_done && k_b == 0) k_b = k;
         tick;
      end
      check("wr_we_low_cycles", 32'(cnt_a), 32'd1);
      check("wr_we_low_at", 32'(k_a), 32'd2);
      check("wr_dq_oe_cycles", 32'(cnt_b), 32'd3);
      check("wr_oe_stays_high", 32'(cnt_c), 32'd0);
      check("wr_base_untouched", 32'(cnt_d), 32'd0);
      check("wr_done_cycle", 32'(k_b), 32'd4);

      // ---------------- conflict, fixed data priority ----------------
      base_dq_i = 32'h1111_2222;
      i_req = 1'b1; i_addr = 32'h8000_0020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0004;
      #1;
      check("cf_d_ready", 32'(d_ready), 32'd1);
      check("cf_i_ready", 32'(i_ready), 32'd0);
      tick;
      d_req = 1'b0;
      first = 0; flag = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (i_ready) begin first = k; flag = d_done; break; end
         tick;
      end
      base_dq_i = 32'h3333_4444;
      check("cf_i_ready_cycle", 32'(first), 32'd4);
      check("cf_i_ready_in_d_done", 32'(flag), 32'd1);
      check("cf_d_rdata", d_rdata, 32'h1111_2222);
      tick;
      i_req = 1'b0;
      check("cf_i_addr", 32'(base_addr), 32'h0000_0008);
      check("cf_i_oe_n", 32'(base_oe_n), 32'd0);
      k_a = 0;
      for (int k = 1; k <= 6; k++) begin
         if (i_done && k_a == 0) k_a = k;
         tick;
      end
      check("cf_i_done_cycle", 32'(k_a), 32'd4);
      check("cf_i_rdata", i_rdata, 32'h3333_4444);
      check("cf_d_rdata_hold", d_rdata, 32'h1111_2222);

      // ---------------- parallel access to both banks ----------------
      base_dq_i = 32'h0BAD_0002; ext_dq_i = 32'hCAFE_0001;
      i_req = 1'b1; i_addr = 32'h8000_0100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8040_0100;
      #1;
      check("par_i_ready", 32'(i_ready), 32'd1);
      check("par_d_ready", 32'(d_ready), 32'd1);
      tick;
      i_req = 1'b0; d_req = 1'b0;
      k_a = 0; k_b = 0;
      for (int k = 1; k <= 6; k++) begin
         if (i_done && k_a == 0) k_a = k;
         if (d_done && k_b == 0) k_b = k;
         tick;
      end
      check("par_i_done_cycle", 32'(k_a), 32'd4);
      check("par_d_done_cycle", 32'(k_b), 32'd4);
      check("par_i_rdata", i_rdata, 32'h0BAD_0002);
      check("par_d_rdata", d_rdata, 32'hCAFE_0001);

      // ---------------- out-of-window addresses ----------------
      d_req = 1'b1; d_addr = 32'h9000_0000;
      i_req = 1'b1; i_addr = 32'h0000_1000;
      #1;
      check("err_d_ready", 32'(d_ready), 32'd1);
      check("err_i_ready", 32'(i_ready), 32'd1);
      tick;
      d_req = 1'b0; i_req = 1'b0;
      check("err_d_done", 32'(d_done), 32'd1);
      check("err_d_err", 32'(d_err), 32'd1);
      check("err_d_rdata", d_rdata, 32'd0);
      check("err_i_done", 32'(i_done), 32'd1);
      check("err_i_rdata", i_rdata, 32'd0);
      check("err_no_strobe", 32'({base_ce_n, ext_ce_n}), 32'd3);
      tick;
      check("err_d_done_clear", 32'(d_done), 32'd0);
      check("err_d_err_clear", 32'(d_err), 32'd0);

      // ---------------- round-robin on repeated conflicts ----------------
      ri_req = 1'b1; ri_addr = 32'h8000_0000;
      rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'h8000_0040;
      #1;
      ng = 0;
      for (int j = 0; j < 3; j++) begin gw[j] = -1; gk[j] = -1; end
      for (int k = 0; k < 20 && ng < 3; k++) begin
         if (rr_d_ready) begin gw[ng] = 1; gk[ng] = k; ng++; end
         else if (rr_i_ready) begin gw[ng] = 0; gk[ng] = k; ng++; end
         tick;
      end
      ri_req = 1'b0; rd_req = 1'b0;
      check("rr_grant0_data", 32'(gw[0]), 32'd1);
      check("rr_grant1_instr", 32'(gw[1]), 32'd0);
      check("rr_grant2_data", 32'(gw[2]), 32'd1);
      check("rr_grant1_cycle", 32'(gk[1]), 32'd4);
      check("rr_grant2_cycle", 32'(gk[2]), 32'd8);
      for (int k = 0; k < 6; k++) tick;

      // ---------------- reset in the middle of a write ----------------
      d_req = 1'b1; d_we = 1'b1; d_sel = 4'hF;
      d_addr = 32'h8000_0010; d_wdata = 32'h1234_5678;
      #1;
      tick;
      d_req = 1'b0; d_we = 1'b0;
      tick;
      check("mid_we_n_active", 32'(base_we_n), 32'd0);
      check("mid_dq_o", base_dq_o, 32'h1234_5678);
      rst = 1'b1;
      tick;
      check("mid_rst_strobes", 32'({base_ce_n, base_oe_n, base_we_n}), 32'd7);
      check("mid_rst_be_n", 32'(base_be_n), 32'hF);
      check("mid_rst_dq_oe", 32'(base_dq_oe), 32'd0);
      check("mid_rst_d_ready", 32'(d_ready), 32'd0);
      rst = 1'b0;
      cnt_a = 0; cnt_b = 0;
      for (int k = 1; k <= 6; k++) begin
         if (d_done) cnt_a++;
         if (!base_ce_n) cnt_b++;
         tick;
      end
      check("mid_no_done", 32'(cnt_a), 32'd0);
      check("mid_no_strobe", 32'(cnt_b), 32'd0);

      v_b = 32'd0; v_c = 32'd0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_arb_ctrl.md
SRAM_ARB_CTRL -- requirements
Module: sram_arb_ctrl

Interface
REQ-001 SHALL take parameter WAIT_CYCLES, default 1, giving the SRAM strobe-active cycles per access; legal range 0..15.
REQ-002 SHALL take parameter BANK_BIT, default 22, naming the address bit that selects base (0) or ext (1).
REQ-003 SHALL take parameter PRIO_MODE, default 0, where 0 means data port always wins a conflict and 1 means round-robin on conflict.
REQ-004 SHALL have clk, input, 1 bit: single clock; all logic sequential on its rising edge.
REQ-005 SHALL have rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have instruction-port inputs i_req (1) and i_addr (32), and outputs i_ready (1), i_done (1) and i_rdata (32); this port is read-only.
REQ-007 SHALL have data-port inputs d_req (1), d_we (1), d_sel (4), d_addr (32) and d_wdata (32), and outputs d_ready (1), d_done (1), d_err (1) and d_rdata (32).
REQ-008 SHALL have base-bank outputs base_addr (20), base_be_n (4), base_ce_n, base_oe_n, base_we_n, base_dq_o (32) and base_dq_oe (1), and input base_dq_i (32).
REQ-009 SHALL have ext-bank ports identical to REQ-008 with the ext_ prefix.

Function
REQ-010 SHALL decode addresses 0x8000_0000..0x807F_FFFF as valid; SRAM word address = addr[21:2]; bank = addr[BANK_BIT].
REQ-011 SHALL accept a request on the edge where req && ready are both high; masters hold their request payload stable until acceptance.
REQ-012 SHALL run one FSM per bank with states IDLE -> SETUP (1 cycle) -> ACTIVE (WAIT_CYCLES cycles, skipped if 0) -> HOLD (1 cycle) -> DONE (1 cycle) -> IDLE.
REQ-013 SHALL in SETUP, ACTIVE and HOLD drive ce_n=0, a registered address, and be_n = ~d_sel for writes or 4'b0000 for reads.
REQ-014 SHALL for reads hold oe_n=0 across SETUP through HOLD, and capture dq_i into rdata on the edge that ends HOLD.
REQ-015 SHALL for writes hold dq_oe=1 and dq_o=wdata across SETUP through HOLD, with we_n=0 only in ACTIVE, or only in HOLD when WAIT_CYCLES=0; oe_n stays 1.
REQ-016 SHALL pulse done for exactly one cycle in DONE with rdata valid, giving a total latency of WAIT_CYCLES+3 cycles from acceptance to done.
REQ-017 SHALL raise bank ready in IDLE and DONE, so an access accepted in DONE goes directly to SETUP and achieves back-to-back throughput of one access per WAIT_CYCLES+3 cycles.
REQ-018 SHALL serve requests to different banks in the same cycle in parallel with independent FSMs.
REQ-019 SHALL on a same-bank same-cycle conflict, with PRIO_MODE=0, grant the data port and hold i_ready low.
REQ-020 SHALL on a same-bank same-cycle conflict, with PRIO_MODE=1, alternate grants using a per-bank last-winner bit initialised to instruction, so data wins the first conflict.
REQ-021 SHALL drive a port's ready only from the state of the bank its current address selects; ready is combinational from registered state plus address.
REQ-022 SHALL treat a data-port address outside the valid range as follows: always accepted; no SRAM strobe; next cycle d_done=1, d_err=1, d_rdata=0.
REQ-023 SHALL treat an instruction-port address outside the valid range as follows: accepted; next cycle i_done=1, i_rdata=0.
REQ-024 SHALL route each port's rdata and done only from the bank that serviced that port; rdata holds its value until that port's next done.

Reset
REQ-025 SHALL on rst=1, at the next edge, return all FSMs to IDLE; force ce_n, oe_n and we_n to 1, be_n to 4'hF, dq_oe to 0, and addr and dq_o to 0.
REQ-026 SHALL on that reset edge also clear all done and err flags to 0, clear rdata to 0, and reset the last-winner bits to instruction.
REQ-027 SHALL when reset arrives mid-access abort the access with no done pulse, and keep ready low during reset.

Verification
REQ-028 SHALL be verified by a read with WAIT_CYCLES=1: d_req read at 0x8000_0010 -> base_addr=0x00004, oe_n low 3 cycles, d_done high 4 cycles after acceptance with d_rdata equal to base_dq_i.
REQ-029 SHALL be verified by a write: d_we=1, d_sel=4'b0011, addr 0x8040_0008, wdata 0xDEADBEEF -> ext_be_n=4'b1100, ext_we_n low exactly 1 cycle, ext_dq_oe high 3 cycles.
REQ-030 SHALL be verified by a conflict: i_req and d_req both to 0x8000_0000 region, PRIO_MODE=0 -> data granted, i_ready low until the data DONE cycle, instruction then accepted.
REQ-031 SHALL be verified by round-robin: PRIO_MODE=1 with three consecutive conflicts -> grant order data, instr, data.
REQ-032 SHALL be verified by a parallel access: i_addr 0x8000_0100 and d_addr 0x8040_0100 in the same cycle -> both accepted, both done in the same cycle.
REQ-033 SHALL be verified by reset mid-access plus an error case: rst during ACTIVE -> all strobes high next cycle, no done pulse; d_addr 0x9000_0000 -> d_err and d_done high 1 cycle later, d_rdata=0.
